// File: rtl/led_band_pkg.sv
// Shared constants, state type and phase-length helper for the LED band
// function-control write sequencer.
package led_band_pkg;

    localparam int unsigned FCWRTEN_EDGES = 15;
    localparam int unsigned FC_WIDTH      = 48;
    localparam int unsigned WRTFC_EDGES   = 5;
    localparam int unsigned EDGE_CNT_W    = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EN   = 2'd1,
        DATA = 2'd2,
        WR   = 2'd3
    } fc_seq_state_t;

    // Number of SCLK rising edges that make up each phase of the FC write.
    function automatic logic [EDGE_CNT_W-1:0] phase_edges(input fc_seq_state_t st);
        logic [EDGE_CNT_W-1:0] edges;
        case (st)
            EN:      edges = EDGE_CNT_W'(FCWRTEN_EDGES);
            DATA:    edges = EDGE_CNT_W'(FC_WIDTH);
            WR:      edges = EDGE_CNT_W'(WRTFC_EDGES);
            default: edges = {EDGE_CNT_W{1'b0}};
        endcase
        return edges;
    endfunction

endpackage

// File: rtl/led_sclk_gen.sv
// Free-running SCLK divider for the FC sequence; strobes flag the clk edge at
// which sclk is about to rise or fall.
module led_sclk_gen
    import led_band_pkg::*;
#(
    parameter int unsigned SCLK_HALF = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int unsigned CNT_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SCLK_HALF - 1);

    logic [CNT_W-1:0] half_cnt_r;
    logic             sclk_r;
    logic             wrap_s;

    // Half-period terminal count decides the toggle edge.
    always_comb begin
        wrap_s   = run && (half_cnt_r == HALF_LAST);
        rise_stb = wrap_s && !sclk_r;
        fall_stb = wrap_s && sclk_r;
    end

    // Divider state; sclk parks low whenever the sequence is not running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_cnt_r <= {CNT_W{1'b0}};
            sclk_r     <= 1'b0;
        end else if (!run) begin
            half_cnt_r <= {CNT_W{1'b0}};
            sclk_r     <= 1'b0;
        end else if (wrap_s) begin
            half_cnt_r <= {CNT_W{1'b0}};
            sclk_r     <= ~sclk_r;
        end else begin
            half_cnt_r <= half_cnt_r + CNT_W'(1);
            sclk_r     <= sclk_r;
        end
    end

    assign sclk = sclk_r;

endmodule

// File: rtl/led_band_fc_sequencer.sv
// Arbitrates SCLK/LAT between the grayscale streamer and the FC register write
// sequence (FCWRTEN, 48-bit shift, WRTFC) for one LED band.
module led_band_fc_sequencer
    import led_band_pkg::*;
#(
    parameter int unsigned SCLK_HALF     = 2,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic fc_start,
    input  logic gs_busy,
    input  logic gs_sclk,
    input  logic gs_lat,
    output logic gs_hold,
    output logic busy,
    output logic done,
    output logic SCLK,
    output logic LAT
);

    fc_seq_state_t         state_r, state_nxt_s;
    logic [EDGE_CNT_W-1:0] edge_cnt_r, edge_cnt_nxt_s;
    logic                  pending_r, pending_nxt_s;
    logic                  sclk_r, sclk_nxt_s;
    logic                  lat_r, lat_nxt_s;
    logic                  busy_r, busy_nxt_s;
    logic                  done_r, done_nxt_s;
    logic                  hold_r, hold_nxt_s;
    logic                  enter_en_s;
    logic                  phase_end_s;
    logic                  gen_run_s;
    logic                  gen_sclk_s;
    logic                  rise_s;
    logic                  fall_s;

    assign gen_run_s = (state_r != IDLE);

    led_sclk_gen #(
        .SCLK_HALF (SCLK_HALF)
    ) u_sclk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (gen_run_s),
        .sclk     (gen_sclk_s),
        .rise_stb (rise_s),
        .fall_stb (fall_s)
    );

    // Next-state, edge counting and next output values.
    always_comb begin
        state_nxt_s    = state_r;
        edge_cnt_nxt_s = edge_cnt_r + (rise_s ? EDGE_CNT_W'(1) : EDGE_CNT_W'(0));
        sclk_nxt_s     = gen_sclk_s ^ (rise_s | fall_s);
        lat_nxt_s      = lat_r;
        done_nxt_s     = 1'b0;
        enter_en_s     = 1'b0;
        // LAT only ever moves on the falling SCLK transition that closes a phase.
        phase_end_s    = fall_s && (edge_cnt_r == phase_edges(state_r));

        case (state_r)
            IDLE: begin
                edge_cnt_nxt_s = {EDGE_CNT_W{1'b0}};
                if (pending_r && !gs_busy) begin
                    state_nxt_s = EN;
                    sclk_nxt_s  = 1'b0;
                    lat_nxt_s   = 1'b1;
                    enter_en_s  = 1'b1;
                end else begin
                    sclk_nxt_s  = gs_sclk;
                    lat_nxt_s   = gs_lat;
                end
            end
            EN: begin
                if (phase_end_s) begin
                    state_nxt_s    = DATA;
                    lat_nxt_s      = 1'b0;
                    edge_cnt_nxt_s = {EDGE_CNT_W{1'b0}};
                end else begin
                    state_nxt_s    = EN;
                end
            end
            DATA: begin
                if (phase_end_s) begin
                    state_nxt_s    = WR;
                    lat_nxt_s      = 1'b1;
                    edge_cnt_nxt_s = {EDGE_CNT_W{1'b0}};
                end else begin
                    state_nxt_s    = DATA;
                end
            end
            WR: begin
                if (phase_end_s) begin
                    state_nxt_s    = IDLE;
                    lat_nxt_s      = 1'b0;
                    sclk_nxt_s     = 1'b0;
                    done_nxt_s     = 1'b1;
                    edge_cnt_nxt_s = {EDGE_CNT_W{1'b0}};
                end else begin
                    state_nxt_s    = WR;
                end
            end
            default: begin
                state_nxt_s    = IDLE;
                sclk_nxt_s     = 1'b0;
                lat_nxt_s      = 1'b0;
                edge_cnt_nxt_s = {EDGE_CNT_W{1'b0}};
            end
        endcase

        // A request arriving while the sequence starts is kept for a re-run.
        pending_nxt_s = fc_start || (pending_r && !enter_en_s);
        busy_nxt_s    = (state_nxt_s != IDLE);
        hold_nxt_s    = pending_nxt_s || busy_nxt_s;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            edge_cnt_r <= {EDGE_CNT_W{1'b0}};
            pending_r  <= INIT_ON_RESET;
            sclk_r     <= 1'b0;
            lat_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            hold_r     <= INIT_ON_RESET;
        end else begin
            state_r    <= state_nxt_s;
            edge_cnt_r <= edge_cnt_nxt_s;
            pending_r  <= pending_nxt_s;
            sclk_r     <= sclk_nxt_s;
            lat_r      <= lat_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            hold_r     <= hold_nxt_s;
        end
    end

    assign SCLK    = sclk_r;
    assign LAT     = lat_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign gs_hold = hold_r;

endmodule

// File: tb/tb_led_band_fc_sequencer.sv
// Bench for led_band_fc_sequencer: three instances (SCLK_HALF 2/5/1) checked
// cycle by cycle against a closed-form timing model of the FC write.
module tb_led_band_fc_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic gs_busy = 1'b0;
    logic gs_sclk = 1'b0;
    logic gs_lat = 1'b0;
    logic fc_start_a = 1'b0, fc_start_b = 1'b0, fc_start_c = 1'b0;
    logic hold_a, busy_a, done_a, sclk_a, lat_a;
    logic hold_b, busy_b, done_b, sclk_b, lat_b;
    logic hold_c, busy_c, done_c, sclk_c, lat_c;

    int total = 0;
    int bad = 0;
    int done_cnt_a = 0;

    always #5 clk = ~clk;

    led_band_fc_sequencer #(.SCLK_HALF(2), .INIT_ON_RESET(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .fc_start(fc_start_a), .gs_busy(gs_busy),
        .gs_sclk(gs_sclk), .gs_lat(gs_lat), .gs_hold(hold_a), .busy(busy_a),
        .done(done_a), .SCLK(sclk_a), .LAT(lat_a));

    led_band_fc_sequencer #(.SCLK_HALF(5), .INIT_ON_RESET(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .fc_start(fc_start_b), .gs_busy(gs_busy),
        .gs_sclk(gs_sclk), .gs_lat(gs_lat), .gs_hold(hold_b), .busy(busy_b),
        .done(done_b), .SCLK(sclk_b), .LAT(lat_b));

    led_band_fc_sequencer #(.SCLK_HALF(1), .INIT_ON_RESET(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .fc_start(fc_start_c), .gs_busy(gs_busy),
        .gs_sclk(gs_sclk), .gs_lat(gs_lat), .gs_hold(hold_c), .busy(busy_c),
        .done(done_c), .SCLK(sclk_c), .LAT(lat_c));

    always @(negedge clk) begin
        if (done_a) done_cnt_a <= done_cnt_a + 1;
    end

    // Reference timing: SCLK starts low at cycle 1 and toggles every h cycles,
    // so the fall following rise k lands on cycle 1 + 2*h*k.
    function automatic int seq_end(input int h);
        return 1 + 2 * h * 68;
    endfunction

    function automatic logic exp_lat(input int n, input int h);
        return logic'((n < 1 + 2 * h * 15) || ((n >= 1 + 2 * h * 63) && (n < seq_end(h))));
    endfunction

    function automatic logic exp_sclk(input int n, input int h);
        if (n >= seq_end(h)) return 1'b0;
        return logic'(((n - 1) / h) % 2);
    endfunction

    task automatic chk(input string tag, input logic obs, input logic expv);
        total = total + 1;
        assert (obs === expv) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        total = total + 1;
        assert (obs == expv) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic get(input int sel, output logic s, output logic l,
                       output logic b, output logic d, output logic hd);
        case (sel)
            0: begin s = sclk_a; l = lat_a; b = busy_a; d = done_a; hd = hold_a; end
            1: begin s = sclk_b; l = lat_b; b = busy_b; d = done_b; hd = hold_b; end
            default: begin s = sclk_c; l = lat_c; b = busy_c; d = done_c; hd = hold_c; end
        endcase
    endtask

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0: fc_start_a = v;
            1: fc_start_b = v;
            default: fc_start_c = v;
        endcase
    endtask

    // Checks cycles 1..end of one sequence (or 1..stop when stop>0);
    // fc_start is pulsed after the checks of cycles p1 and p2.
    task automatic run_seq(input int sel, input int h, input int p1, input int p2,
                           input int stop, input string name);
        int e;
        int last;
        int rises;
        logic prev, s, l, b, d, hd;
        e = seq_end(h);
        last = (stop > 0) ? stop : e;
        rises = 0;
        prev = 1'b0;
        for (int n = 1; n <= last; n++) begin
            @(negedge clk);
            get(sel, s, l, b, d, hd);
            chk({name, " sclk"}, s, exp_sclk(n, h));
            chk({name, " lat"}, l, exp_lat(n, h));
            chk({name, " busy"}, b, logic'(n < e));
            chk({name, " done"}, d, logic'(n == e));
            chk({name, " gs_hold"}, hd, logic'((n < e) || (p1 != 0)));
            if (s && !prev) rises++;
            prev = s;
            set_start(sel, logic'((n == p1) || (n == p2)));
        end
        set_start(sel, 1'b0);
        if (stop == 0) chk_int({name, " sclk_rises"}, rises, 68);
    endtask

    task automatic chk_idle(input int sel, input string name);
        logic s, l, b, d, hd;
        get(sel, s, l, b, d, hd);
        chk({name, " sclk"}, s, gs_sclk);
        chk({name, " lat"}, l, gs_lat);
        chk({name, " busy"}, b, 1'b0);
        chk({name, " done"}, d, 1'b0);
        chk({name, " gs_hold"}, hd, 1'b0);
    endtask

    initial begin
        int base;
        logic ps, pl;

        repeat (3) @(negedge clk);
        chk("rst sclk", sclk_a, 1'b0);
        chk("rst lat", lat_a, 1'b0);
        chk("rst busy", busy_a, 1'b0);
        chk("rst done", done_a, 1'b0);
        chk("rst hold_a", hold_a, 1'b1);
        chk("rst hold_b", hold_b, 1'b0);
        chk("rst hold_c", hold_c, 1'b0);

        // Automatic FC write after reset release.
        rst_n = 1'b1;
        run_seq(0, 2, 0, 0, 0, "init_a");
        @(negedge clk);
        chk_idle(0, "init_a after");
        chk("b untouched", busy_b, 1'b0);

        // Request while the streamer is busy: hold, then pass streamer through.
        gs_busy = 1'b1;
        fc_start_a = 1'b1;
        @(negedge clk);
        fc_start_a = 1'b0;
        chk("hold immediate", hold_a, 1'b1);
        for (int i = 0; i < 20; i++) begin
            ps = logic'($urandom_range(0, 1));
            pl = logic'($urandom_range(0, 1));
            gs_sclk = ps;
            gs_lat = pl;
            @(negedge clk);
            chk("pass sclk", sclk_a, ps);
            chk("pass lat", lat_a, pl);
            chk("pass busy", busy_a, 1'b0);
            chk("pass hold", hold_a, 1'b1);
        end
        gs_sclk = 1'b0;
        gs_lat = 1'b0;
        gs_busy = 1'b0;
        base = done_cnt_a;
        run_seq(0, 2, 10, 20, 0, "chain_a1");
        run_seq(0, 2, 0, 0, 0, "chain_a2");
        @(negedge clk);
        chk_idle(0, "chain_a after");
        chk_int("chain done pulses", done_cnt_a - base, 2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no third seq", busy_a, 1'b0);
        end

        // SCLK_HALF=1 full sequence.
        fc_start_c = 1'b1;
        @(negedge clk);
        fc_start_c = 1'b0;
        chk("hold_c", hold_c, 1'b1);
        run_seq(2, 1, 0, 0, 0, "h1_c");
        @(negedge clk);
        chk_idle(2, "h1_c after");

        // SCLK_HALF=5 full sequence.
        fc_start_b = 1'b1;
        @(negedge clk);
        fc_start_b = 1'b0;
        run_seq(1, 5, 0, 0, 0, "h5_b");
        @(negedge clk);
        chk_idle(1, "h5_b after");

        // Abort at cycle 100 by asynchronous reset.
        fc_start_b = 1'b1;
        @(negedge clk);
        fc_start_b = 1'b0;
        run_seq(1, 5, 0, 0, 100, "abort_b");
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort sclk", sclk_b, 1'b0);
        chk("abort lat", lat_b, 1'b0);
        chk("abort busy", busy_b, 1'b0);
        chk("abort hold", hold_b, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            chk("no restart busy", busy_b, 1'b0);
            chk("no restart lat", lat_b, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
